// File: rtl/gd_quad_responder_pkg.sv
// Shared types and constants for the gradient-descent quadratic responder.
// Contents: FSM state enum, Q24.8 format constants, clamp helper and the
//           registered result bundle driven onto the handshake interface.
package gd_pkg;

    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned Q_W       = 32;
    localparam int unsigned COORD_W   = 8;
    localparam int unsigned ITER_W    = 8;
    localparam int unsigned WIDE_W    = 64;

    // Coordinate clamp keeps the integer part inside the 8-bit signed range
    localparam logic signed [Q_W-1:0] Q_MIN   = 32'shFFFF_8000;
    localparam logic signed [Q_W-1:0] Q_MAX   = 32'sh0000_7FFF;
    localparam logic signed [Q_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL0,
        S_EVAL1,
        S_EVAL2,
        S_EVAL3,
        S_UPDATE,
        S_DONE
    } gd_state_e;

    typedef struct packed {
        logic [Q_W-1:0]     z_min;
        logic [COORD_W-1:0] final_a;
        logic [COORD_W-1:0] final_b;
        logic [COORD_W-1:0] final_c;
        logic [COORD_W-1:0] final_d;
        logic [ITER_W-1:0]  iter_count;
        logic               converged;
    } gd_result_t;

    // Clamp a wide signed Q24.8 value into [Q_MIN, Q_MAX]
    function automatic logic signed [Q_W-1:0] clamp_q(input logic signed [WIDE_W-1:0] v);
        logic signed [WIDE_W-1:0] lo;
        logic signed [WIDE_W-1:0] hi;
        lo = WIDE_W'(Q_MIN);
        hi = WIDE_W'(Q_MAX);
        if (v < lo) begin
            return Q_MIN;
        end else if (v > hi) begin
            return Q_MAX;
        end
        return Q_W'(v);
    endfunction

endpackage

// File: rtl/gd_quad_responder_if.sv
// Start/done handshake bundle between the sweep harness and the responder.
// master: drives start_op and the four initial coordinates, reads results.
// slave : the responder; reads the request, drives z_min, final_*, iter_count,
//         converged and done_op.
interface gd_quad_responder_if;
    import gd_pkg::*;

    logic                      start_op;
    logic signed [COORD_W-1:0] a_initial;
    logic signed [COORD_W-1:0] b_initial;
    logic signed [COORD_W-1:0] c_initial;
    logic signed [COORD_W-1:0] d_initial;
    logic        [Q_W-1:0]     z_min;
    logic signed [COORD_W-1:0] final_a_at_min;
    logic signed [COORD_W-1:0] final_b_at_min;
    logic signed [COORD_W-1:0] final_c_at_min;
    logic signed [COORD_W-1:0] final_d_at_min;
    logic        [ITER_W-1:0]  iter_count;
    logic                      converged;
    logic                      done_op;

    modport master (
        output start_op, a_initial, b_initial, c_initial, d_initial,
        input  z_min, final_a_at_min, final_b_at_min, final_c_at_min,
               final_d_at_min, iter_count, converged, done_op
    );

    modport slave (
        input  start_op, a_initial, b_initial, c_initial, d_initial,
        output z_min, final_a_at_min, final_b_at_min, final_c_at_min,
               final_d_at_min, iter_count, converged, done_op
    );

endinterface

// File: rtl/gd_quad_responder_sq_eval.sv
// Combinational per-coordinate evaluator (the single shared multiplier).
// i_x      : coordinate, signed Q24.8
// i_target : bowl centre for this coordinate, signed integer
// o_sq     : ((x - T<<8)^2) >>> 8, saturated to 32'h7FFF_FFFF
// o_grad   : gradient 2*(x - T<<8), signed Q24.8
module gd_sq_eval
    import gd_pkg::*;
(
    input  logic signed [Q_W-1:0]     i_x,
    input  logic signed [COORD_W-1:0] i_target,
    output logic        [Q_W-1:0]     o_sq,
    output logic signed [Q_W-1:0]     o_grad
);

    logic signed [Q_W-1:0]    w_tgt_q;
    logic signed [Q_W-1:0]    w_diff;
    logic signed [WIDE_W-1:0] w_prod;
    logic signed [WIDE_W-1:0] w_sq_full;

    assign w_tgt_q   = {{(Q_W-COORD_W-FRAC_BITS){i_target[COORD_W-1]}}, i_target, FRAC_BITS'(0)};
    assign w_diff    = i_x - w_tgt_q;
    assign w_prod    = WIDE_W'(w_diff) * WIDE_W'(w_diff);
    assign w_sq_full = w_prod >>> FRAC_BITS;

    // A square is never negative, so only the upper bound needs saturating
    assign o_sq   = (w_sq_full > WIDE_W'(SAT_MAX)) ? SAT_MAX : w_sq_full[Q_W-1:0];
    assign o_grad = w_diff <<< 1;

endmodule

// File: rtl/gd_quad_responder.sv
// Gradient-descent responder on the bowl z = sum_k (x_k - T_k)^2, Q24.8.
// Ports: clk, rst (async, active-high); bus (slave modport) carrying
//        start_op, a..d_initial in and z_min, final_*_at_min, iter_count,
//        converged, done_op out. All outputs are registered.
// One coordinate is evaluated per cycle (EVAL0..EVAL3), then UPDATE tracks the
// best point, tests the gradient bound and steps the coordinates.
module gd_quad_responder
    import gd_pkg::*;
#(
    parameter int unsigned         NUM_ITERATIONS   = 50,
    parameter logic signed [31:0]  LEARNING_RATE    = 32'sh0000_0040,
    parameter logic signed [7:0]   TARGET_A         = 8'sd0,
    parameter logic signed [7:0]   TARGET_B         = 8'sd0,
    parameter logic signed [7:0]   TARGET_C         = 8'sd0,
    parameter logic signed [7:0]   TARGET_D         = 8'sd0,
    parameter logic signed [31:0]  LOWER_CONV_BOUND = 32'shFFFF_FFC0,
    parameter logic signed [31:0]  UPPER_CONV_BOUND = 32'sh0000_0040
) (
    input  logic              clk,
    input  logic              rst,
    gd_quad_responder_if.slave bus
);

    localparam int unsigned NUM_COORD = 4;
    localparam int unsigned CNT_EXT_W = ITER_W + 1;

    gd_state_e r_state;
    gd_state_e w_next_state;

    logic signed [Q_W-1:0]     r_x      [NUM_COORD];
    logic signed [Q_W-1:0]     r_g      [NUM_COORD];
    logic        [COORD_W-1:0] r_best_x [NUM_COORD];
    logic        [Q_W-1:0]     r_z;
    logic        [Q_W-1:0]     r_best_z;
    logic        [ITER_W-1:0]  r_cnt;
    gd_result_t                r_res;
    logic                      r_done;

    logic signed [Q_W-1:0]     w_sel_x;
    logic signed [COORD_W-1:0] w_sel_t;
    logic        [1:0]         w_sel_idx;
    logic        [Q_W-1:0]     w_sq;
    logic signed [Q_W-1:0]     w_grad;
    logic        [Q_W:0]       w_sum;
    logic        [Q_W-1:0]     w_z_next;
    logic signed [WIDE_W-1:0]  w_step   [NUM_COORD];
    logic signed [Q_W-1:0]     w_x_next [NUM_COORD];
    logic                      w_all_in;
    logic                      w_last;
    logic                      w_finish;
    logic                      w_better;

    // Route the coordinate under evaluation to the shared evaluator
    always_comb begin
        w_sel_x   = r_x[0];
        w_sel_t   = TARGET_A;
        w_sel_idx = 2'd0;
        case (r_state)
            S_EVAL1: begin w_sel_x = r_x[1]; w_sel_t = TARGET_B; w_sel_idx = 2'd1; end
            S_EVAL2: begin w_sel_x = r_x[2]; w_sel_t = TARGET_C; w_sel_idx = 2'd2; end
            S_EVAL3: begin w_sel_x = r_x[3]; w_sel_t = TARGET_D; w_sel_idx = 2'd3; end
            default: ;
        endcase
    end

    gd_sq_eval u_sq_eval (
        .i_x      (w_sel_x),
        .i_target (w_sel_t),
        .o_sq     (w_sq),
        .o_grad   (w_grad)
    );

    // Saturating z accumulator; EVAL0 starts a fresh sum
    always_comb begin
        w_sum    = ((r_state == S_EVAL0) ? (Q_W+1)'(0) : {1'b0, r_z}) + {1'b0, w_sq};
        w_z_next = (w_sum > {1'b0, SAT_MAX}) ? SAT_MAX : w_sum[Q_W-1:0];
    end

    // Gradient bound test and next coordinates for the step
    always_comb begin
        w_all_in = 1'b1;
        for (int k = 0; k < NUM_COORD; k++) begin
            if ((r_g[k] < LOWER_CONV_BOUND) || (r_g[k] > UPPER_CONV_BOUND)) begin
                w_all_in = 1'b0;
            end
            w_step[k]   = (WIDE_W'(LEARNING_RATE) * WIDE_W'(r_g[k])) >>> FRAC_BITS;
            w_x_next[k] = clamp_q(WIDE_W'(r_x[k]) - w_step[k]);
        end
    end

    assign w_last   = ((CNT_EXT_W'(r_cnt) + CNT_EXT_W'(1)) == CNT_EXT_W'(NUM_ITERATIONS));
    assign w_finish = w_all_in || w_last;
    // Strict compare so ties keep the earlier point
    assign w_better = (r_z < r_best_z);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start_op) w_next_state = S_LOAD;
            S_LOAD:   w_next_state = S_EVAL0;
            S_EVAL0:  w_next_state = S_EVAL1;
            S_EVAL1:  w_next_state = S_EVAL2;
            S_EVAL2:  w_next_state = S_EVAL3;
            S_EVAL3:  w_next_state = S_UPDATE;
            S_UPDATE: w_next_state = w_finish ? S_DONE : S_EVAL0;
            S_DONE:   if (!bus.start_op) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load, evaluate, track best point and step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_COORD; k++) begin
                r_x[k]      <= '0;
                r_g[k]      <= '0;
                r_best_x[k] <= '0;
            end
            r_z      <= '0;
            r_best_z <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_x[0]   <= Q_W'(bus.a_initial) <<< FRAC_BITS;
                    r_x[1]   <= Q_W'(bus.b_initial) <<< FRAC_BITS;
                    r_x[2]   <= Q_W'(bus.c_initial) <<< FRAC_BITS;
                    r_x[3]   <= Q_W'(bus.d_initial) <<< FRAC_BITS;
                    r_best_z <= SAT_MAX;
                    r_cnt    <= '0;
                end
                S_EVAL0, S_EVAL1, S_EVAL2, S_EVAL3: begin
                    r_z            <= w_z_next;
                    r_g[w_sel_idx] <= w_grad;
                end
                S_UPDATE: begin
                    if (w_better) begin
                        r_best_z <= r_z;
                        for (int k = 0; k < NUM_COORD; k++) begin
                            r_best_x[k] <= r_x[k][FRAC_BITS +: COORD_W];
                        end
                    end
                    if (!w_finish) begin
                        for (int k = 0; k < NUM_COORD; k++) begin
                            r_x[k] <= w_x_next[k];
                        end
                        r_cnt <= r_cnt + ITER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: loaded on DONE entry, held until the next DONE entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res  <= '0;
            r_done <= 1'b0;
        end else begin
            if ((r_state == S_UPDATE) && w_finish) begin
                r_res.z_min      <= w_better ? r_z : r_best_z;
                r_res.final_a    <= w_better ? r_x[0][FRAC_BITS +: COORD_W] : r_best_x[0];
                r_res.final_b    <= w_better ? r_x[1][FRAC_BITS +: COORD_W] : r_best_x[1];
                r_res.final_c    <= w_better ? r_x[2][FRAC_BITS +: COORD_W] : r_best_x[2];
                r_res.final_d    <= w_better ? r_x[3][FRAC_BITS +: COORD_W] : r_best_x[3];
                r_res.iter_count <= r_cnt;
                r_res.converged  <= w_all_in;
                r_done           <= 1'b1;
            end else if ((r_state == S_DONE) && !bus.start_op) begin
                r_done <= 1'b0;
            end
        end
    end

    assign bus.z_min          = r_res.z_min;
    assign bus.final_a_at_min = r_res.final_a;
    assign bus.final_b_at_min = r_res.final_b;
    assign bus.final_c_at_min = r_res.final_c;
    assign bus.final_d_at_min = r_res.final_d;
    assign bus.iter_count     = r_res.iter_count;
    assign bus.converged      = r_res.converged;
    assign bus.done_op        = r_done;

endmodule

// File: tb/tb_gd_quad_responder.sv
// Bench for gd_quad_responder: four DUT instances with different parameter
// sets, directed cases plus $urandom start points, all checked against an
// arithmetic model of the descent run.
module tb_gd_quad_responder;

    localparam int NDUT = 4;
    localparam longint SATV = 64'h7FFF_FFFF;

    logic clk;
    logic rst;

    logic              start [NDUT];
    logic signed [7:0] ai    [NDUT];
    logic signed [7:0] bi    [NDUT];
    logic signed [7:0] ci    [NDUT];
    logic signed [7:0] di    [NDUT];
    logic [31:0]       zo    [NDUT];
    logic [7:0]        fa    [NDUT];
    logic [7:0]        fb    [NDUT];
    logic [7:0]        fc    [NDUT];
    logic [7:0]        fd    [NDUT];
    logic [7:0]        itc   [NDUT];
    logic              cv    [NDUT];
    logic              dn    [NDUT];

    int n_vec = 0;
    int n_err = 0;
    int cur   = 0;

    // Parameter sets per instance
    function automatic int unsigned p_ni(input int i);
        case (i)
            1: return 1;
            2: return 3;
            3: return 20;
            default: return 50;
        endcase
    endfunction

    function automatic int p_lr(input int i);
        case (i)
            2: return 1;
            3: return 32'h60;
            default: return 32'h40;
        endcase
    endfunction

    function automatic int p_t(input int i, input int k);
        if (i == 1) return 127;
        if (i == 3) begin
            case (k)
                0: return 5;
                1: return -7;
                2: return 20;
                default: return -100;
            endcase
        end
        return 0;
    endfunction

    function automatic int p_lo(input int i);
        return (i == 3) ? -256 : -64;
    endfunction

    function automatic int p_hi(input int i);
        return (i == 3) ? 256 : 64;
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        gd_quad_responder_if bus ();
        assign bus.start_op  = start[gi];
        assign bus.a_initial = ai[gi];
        assign bus.b_initial = bi[gi];
        assign bus.c_initial = ci[gi];
        assign bus.d_initial = di[gi];
        assign zo[gi]  = bus.z_min;
        assign fa[gi]  = bus.final_a_at_min;
        assign fb[gi]  = bus.final_b_at_min;
        assign fc[gi]  = bus.final_c_at_min;
        assign fd[gi]  = bus.final_d_at_min;
        assign itc[gi] = bus.iter_count;
        assign cv[gi]  = bus.converged;
        assign dn[gi]  = bus.done_op;

        gd_quad_responder #(
            .NUM_ITERATIONS   (p_ni(gi)),
            .LEARNING_RATE    (32'(p_lr(gi))),
            .TARGET_A         (8'(p_t(gi, 0))),
            .TARGET_B         (8'(p_t(gi, 1))),
            .TARGET_C         (8'(p_t(gi, 2))),
            .TARGET_D         (8'(p_t(gi, 3))),
            .LOWER_CONV_BOUND (32'(p_lo(gi))),
            .UPPER_CONV_BOUND (32'(p_hi(gi)))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d, expected %0d", tag, cur, got, exp);
        end
    endtask

    // Descent run written directly from the bowl definition
    task automatic model(input int idx, input int a, input int b, input int c, input int d,
                         output longint zmin, output int f0, output int f1, output int f2,
                         output int f3, output int iters, output bit conv);
        longint x[4];
        longint t[4];
        longint g[4];
        int     bx[4];
        longint best;
        x[0] = longint'(a) * 256; x[1] = longint'(b) * 256;
        x[2] = longint'(c) * 256; x[3] = longint'(d) * 256;
        for (int k = 0; k < 4; k++) begin
            t[k]  = longint'(p_t(idx, k)) * 256;
            bx[k] = 0;
        end
        best  = SATV;
        iters = 0;
        conv  = 1'b0;
        for (int it = 0; it < 256; it++) begin
            longint z;
            bit inb;
            z   = 0;
            inb = 1'b1;
            for (int k = 0; k < 4; k++) begin
                longint dd;
                longint sq;
                dd = x[k] - t[k];
                sq = (dd * dd) >>> 8;
                if (sq > SATV) sq = SATV;
                z = z + sq;
                if (z > SATV) z = SATV;
                g[k] = 2 * dd;
                if (g[k] < longint'(p_lo(idx)) || g[k] > longint'(p_hi(idx))) inb = 1'b0;
            end
            if (z < best) begin
                best = z;
                for (int k = 0; k < 4; k++) bx[k] = int'(x[k] >>> 8);
            end
            iters = it;
            if (inb) begin
                conv = 1'b1;
                break;
            end
            if (it + 1 == int'(p_ni(idx))) begin
                conv = 1'b0;
                break;
            end
            for (int k = 0; k < 4; k++) begin
                x[k] = x[k] - ((longint'(p_lr(idx)) * g[k]) >>> 8);
                if (x[k] < -32768) x[k] = -32768;
                if (x[k] > 32767)  x[k] = 32767;
            end
        end
        zmin = best;
        f0 = bx[0]; f1 = bx[1]; f2 = bx[2]; f3 = bx[3];
    endtask

    task automatic start_run(input int idx, input int a, input int b, input int c, input int d);
        @(negedge clk);
        ai[idx] = 8'(a); bi[idx] = 8'(b); ci[idx] = 8'(c); di[idx] = 8'(d);
        start[idx] = 1'b1;
    endtask

    // Next posedge is edge 0. drop_edge >= 0 drops start_op after that edge.
    task automatic finish_run(input int idx, input int drop_edge, input int hold);
        longint mz;
        int m0, m1, m2, m3, mit, e;
        bit mcv, seen;
        cur = idx;
        model(idx, int'(ai[idx]), int'(bi[idx]), int'(ci[idx]), int'(di[idx]),
              mz, m0, m1, m2, m3, mit, mcv);
        seen = 1'b0;
        e    = -1;
        while (!seen && e < 2000) begin
            @(posedge clk);
            #1;
            e++;
            if (dn[idx]) seen = 1'b1;
            if (e == drop_edge) start[idx] = 1'b0;
        end
        check_val("latency", e, 1 + 5 * (mit + 1));
        check_val("z_min", zo[idx], mz);
        check_val("final_a", $signed(fa[idx]), m0);
        check_val("final_b", $signed(fb[idx]), m1);
        check_val("final_c", $signed(fc[idx]), m2);
        check_val("final_d", $signed(fd[idx]), m3);
        check_val("iter_count", itc[idx], mit);
        check_val("converged", cv[idx], mcv);
        if (start[idx]) begin
            repeat (hold) @(posedge clk);
            #1;
            check_val("done_held", dn[idx], 1);
            start[idx] = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val("done_fall", dn[idx], 0);
        check_val("z_hold", zo[idx], mz);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int ra, rb, rc, rd;
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            start[i] = 1'b0; ai[i] = '0; bi[i] = '0; ci[i] = '0; di[i] = '0;
        end
        #12;
        for (int i = 0; i < NDUT; i++) begin
            cur = i;
            check_val("rst_z", zo[i], 0);
            check_val("rst_done", dn[i], 0);
            check_val("rst_conv", cv[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Origin start: immediate convergence, done held over 20 cycles
        start_run(0, 0, 0, 0, 0);
        finish_run(0, -1, 20);
        check_val("t1_z", zo[0], 0);
        check_val("t1_iter", itc[0], 0);
        check_val("t1_conv", cv[0], 1);

        // a=16: distance halves each step
        start_run(0, 16, 0, 0, 0);
        finish_run(0, -1, 2);
        check_val("t2_z", zo[0], 4);
        check_val("t2_iter", itc[0], 7);
        check_val("t2_fa", fa[0], 0);

        // Far corner, single evaluation
        start_run(1, -128, -128, -128, -128);
        finish_run(1, -1, 1);
        check_val("t3_z", zo[1], 64'h03F8_0400);
        check_val("t3_conv", cv[1], 0);
        check_val("t3_fa", $signed(fa[1]), -128);

        // start_op dropped during EVAL2: single-cycle done pulse
        start_run(0, -37, 90, 5, -2);
        finish_run(0, 3, 0);

        // Reset during EVAL1 of the a=16 run, then restart with start_op held
        start_run(0, 16, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        cur = 0;
        check_val("mrst_z", zo[0], 0);
        check_val("mrst_iter", itc[0], 0);
        check_val("mrst_conv", cv[0], 0);
        check_val("mrst_done", dn[0], 0);
        @(negedge clk);
        rst = 1'b0;
        finish_run(0, -1, 0);
        check_val("t5_z", zo[0], 4);
        check_val("t5_iter", itc[0], 7);

        // Tiny learning rate, budget-limited run
        start_run(2, 16, 0, 0, 0);
        finish_run(2, -1, 0);
        check_val("t6_conv", cv[2], 0);
        check_val("t6_iter", itc[2], 2);
        check_val("t6_zlt", (zo[2] < 32'h0001_0000) ? 1 : 0, 1);

        // Randomized start points on every parameter set
        for (int n = 0; n < 40; n++) begin
            int idx;
            idx = n % NDUT;
            ra = int'($urandom_range(0, 255)) - 128;
            rb = int'($urandom_range(0, 255)) - 128;
            rc = int'($urandom_range(0, 255)) - 128;
            rd = int'($urandom_range(0, 255)) - 128;
            start_run(idx, ra, rb, rc, rd);
            finish_run(idx, ($urandom_range(0, 3) == 0) ? 3 : -1, int'($urandom_range(0, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
